// File: rtl/sample_accum_if.sv
`default_nettype none
// ============================================================================
// Module   : sample_accum_if
// Brief    : Sample-in / block-sum-out handshake bundle for sample_accum.
// Revision : 1.0
// ============================================================================
interface sample_accum_if #(
    parameter int ACC_W = 8
);
    logic signed [4:0]       in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic                    clear;
    logic signed [ACC_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    ovf;

    modport master (
        output in_data, in_valid, clear, out_ready,
        input  in_ready, out_data, out_valid, ovf
    );

    modport slave (
        input  in_data, in_valid, clear, out_ready,
        output in_ready, out_data, out_valid, ovf
    );
endinterface
`default_nettype wire

// File: rtl/sample_accum.sv
`default_nettype none
// ============================================================================
// Module   : sample_accum
// Brief    : Sums COUNT signed samples per block into a registered result.
//            Define SAMPLE_ACCUM_SATURATE_EN for saturating sums with ovf.
// Revision : 1.0
// ============================================================================
module sample_accum #(
    parameter int COUNT = 4,
    parameter int ACC_W = 8
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    sample_accum_if.slave      bus
);
    localparam int                 c_cnt_w = (COUNT > 2) ? $clog2(COUNT) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(COUNT - 1);

    logic [c_cnt_w-1:0]      cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;

    logic                    w_in_ready;
    logic                    w_accept;
    logic signed [ACC_W-1:0] w_base;
    logic signed [ACC_W-1:0] w_sum;

`ifdef SAMPLE_ACCUM_SATURATE_EN
    logic signed [ACC_W:0]   w_wide;
    logic                    w_clip;
    logic                    w_blk_ovf;
    logic                    blk_ovf_q, blk_ovf_d;
    logic                    ovf_q, ovf_d;
`endif

    always_comb begin
        w_in_ready = !bus.clear && !((cnt_q == c_last) && out_valid_q);
        w_accept   = bus.in_valid && w_in_ready;
        // An EMPTY block starts from zero regardless of the stale accumulator.
        w_base     = (cnt_q == '0) ? '0 : acc_q;
`ifdef SAMPLE_ACCUM_SATURATE_EN
        w_wide    = (ACC_W+1)'(w_base) + (ACC_W+1)'(bus.in_data);
        w_clip    = w_wide[ACC_W] ^ w_wide[ACC_W-1];
        if (!w_clip)
            w_sum = w_wide[ACC_W-1:0];
        else if (w_wide[ACC_W])
            w_sum = {1'b1, {(ACC_W-1){1'b0}}};
        else
            w_sum = {1'b0, {(ACC_W-1){1'b1}}};
        w_blk_ovf = ((cnt_q == '0) ? 1'b0 : blk_ovf_q) | w_clip;
`else
        w_sum     = w_base + ACC_W'(bus.in_data);
`endif
    end

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
`ifdef SAMPLE_ACCUM_SATURATE_EN
        blk_ovf_d   = blk_ovf_q;
        ovf_d       = ovf_q;
`endif
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
`ifdef SAMPLE_ACCUM_SATURATE_EN
            ovf_d       = 1'b0;
`endif
        end
        if (bus.clear) begin
            cnt_d = '0;
            acc_d = '0;
`ifdef SAMPLE_ACCUM_SATURATE_EN
            blk_ovf_d = 1'b0;
`endif
        end else if (w_accept) begin
            // A completing block overrides a same-edge take of the old result.
            if (cnt_q == c_last) begin
                out_data_d  = w_sum;
                out_valid_d = 1'b1;
                cnt_d       = '0;
`ifdef SAMPLE_ACCUM_SATURATE_EN
                ovf_d       = w_blk_ovf;
`endif
            end else begin
                acc_d = w_sum;
                cnt_d = cnt_q + c_cnt_w'(1);
`ifdef SAMPLE_ACCUM_SATURATE_EN
                blk_ovf_d = w_blk_ovf;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef SAMPLE_ACCUM_SATURATE_EN
            blk_ovf_q   <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
`ifdef SAMPLE_ACCUM_SATURATE_EN
            blk_ovf_q   <= blk_ovf_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
`ifdef SAMPLE_ACCUM_SATURATE_EN
    assign bus.ovf       = ovf_q;
`else
    assign bus.ovf       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/sample_accum.md
SAMPLE_ACCUM -- requirements
Module: sample_accum

Interface
REQ-001 SHALL have parameter COUNT, default 4: samples per block; legal range 2..256.
REQ-002 SHALL have parameter ACC_W, default 8: accumulator and result width; legal values >= 5.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_data, input, 5 bits, signed: sample from the upstream register stage.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-008 SHALL have port clear, input, 1 bit: synchronous discard of the partial block.
REQ-009 SHALL have port out_data, output, ACC_W bits, signed: completed block sum.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data holds an untaken result.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream takes out_data this cycle.
REQ-012 SHALL have port ovf, output, 1 bit: sticky overflow flag for the current output result.

Function
REQ-013 SHALL accept a sample when in_valid and in_ready are both 1 at a rising edge.
REQ-014 SHALL drive in_ready = !clear && !(cnt == COUNT-1 && out_valid); no other dependency.
REQ-015 SHALL keep a sample counter cnt (0..COUNT-1), giving states EMPTY (cnt=0) and ACCUM (cnt>0).
REQ-016 SHALL compute sum = (cnt==0 ? 0 : acc) + sign-extend(in_data to ACC_W) on each accept.
REQ-017 SHALL, on an accept with cnt<COUNT-1, set acc <= sum and cnt <= cnt+1.
REQ-018 SHALL, on an accept with cnt==COUNT-1, set out_data <= sum, out_valid <= 1, cnt <= 0 (EMPTY).
REQ-019 SHALL give one-cycle latency: the result is visible the cycle after the final accept.
REQ-020 SHALL clear out_valid on out_ready && out_valid, unless a new result loads the same edge (REQ-018 wins).
REQ-021 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on clear=1, set cnt <= 0 and drop partial acc; out_data, out_valid and ovf are not affected.
REQ-023 SHALL drop (not accept) any in_valid sample in a cycle with clear=1, because in_ready=0.
REQ-024 SHALL track overflow within a block and copy it to ovf when the result loads.
REQ-025 SHALL set ovf=0 whenever out_valid falls.

Reset
REQ-026 SHALL, with reset_n=0, immediately set cnt=0, acc=0, out_data=0, out_valid=0, ovf=0 without waiting for clk.
REQ-027 SHALL resume accepting on the first edge after reset_n rises; in_ready=1 from reset release.

Configuration
REQ-028 SHALL, when SAMPLE_ACCUM_SATURATE_EN is defined, clamp every sum to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-029 SHALL, under that macro, set the block's overflow bit when any clamp occurs.
REQ-030 SHALL, without the macro, wrap sums in two's complement and tie ovf to 0.

Verification (COUNT=4, ACC_W=8 unless stated)
REQ-031 SHALL cover: samples 1,2,3,4 back-to-back, out_ready=1 -> out_data=10, out_valid=1 one cycle after the 4th accept.
REQ-032 SHALL cover: four samples of -16 -> out_data=-64 (8'hC0), ovf=0.
REQ-033 SHALL cover, with ACC_W=6: 15,15,15,15 -> with macro out_data=31, ovf=1; without macro out_data=-4, ovf=0.
REQ-034 SHALL cover: out_ready=0 after block 1 (sum 10), block 2 streams 1,1,1.
REQ-035 SHALL require for REQ-034: in_ready=0 at cnt=3, out_data stays 10; out_ready=1 then releases it, and the next 4th sample gives 4.
REQ-036 SHALL cover: clear asserted after 2 samples, then 5,5,5,5 -> out_data=20.
REQ-037 SHALL cover: reset_n pulsed low mid-block -> all outputs 0 asynchronously, then samples 1,1,1,1 give 4.
